ram_dev: RTL

- HyperBus responder (device/target side) at the word level: the counterpart of the HyperRAM controller PHY.
- Runs in the controller's clk domain. Each clk carries one 16-bit DDR word pair, already de-serialised: [15:8] is the rising-edge byte, [7:0] the falling-edge byte.
- Decodes the 3-word CA phase, applies initial latency and drives RWDS, then serves data from a synchronous memory port or the CR0/CR1 registers.
- Used as a synthesizable memory model in sim and in loopback self-test builds.

---
 rtl/ram_dev_pkg.sv | 45 ++++
 rtl/ram_dev_addr.sv | 46 ++++
 rtl/ram_dev.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ram_dev_pkg.sv
// ram_dev_pkg: shared definitions for the HyperBus word-level responder.
//   - state_t      : responder FSM encoding
//   - CA_RW/AS/BT  : command-address bit positions in the 48-bit CA
//   - LAT_C*       : CR0[7:4] latency codes
//   - lat_clocks() : latency code -> clock count (doubled on 2x latency)
//   - wrap_mask()  : CR0[1:0] burst-length code -> in-group address mask
package ram_dev_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CA0, S_CA1, S_CA2, S_LAT, S_WR, S_RD, S_REGW
  } state_t;

  localparam int CA_RW = 47;  // 1 = read
  localparam int CA_AS = 46;  // 1 = register space
  localparam int CA_BT = 45;  // 1 = linear burst

  localparam logic [3:0] LAT_C3 = 4'b1110;
  localparam logic [3:0] LAT_C4 = 4'b1111;
  localparam logic [3:0] LAT_C5 = 4'b0000;
  localparam logic [3:0] LAT_C6 = 4'b0001;

  // Unlisted codes fall back to the slowest single latency (6).
  function automatic logic [4:0] lat_clocks(input logic [3:0] code, input logic dbl);
    logic [4:0] l;
    case (code)
      LAT_C3:  l = 5'd3;
      LAT_C4:  l = 5'd4;
      LAT_C5:  l = 5'd5;
      LAT_C6:  l = 5'd6;
      default: l = 5'd6;
    endcase
    return dbl ? (l << 1) : l;
  endfunction

  // Mask of the address bits that wrap inside the aligned group.
  function automatic logic [6:0] wrap_mask(input logic [1:0] bl);
    case (bl)
      2'b00:   return 7'd63;
      2'b01:   return 7'd31;
      2'b10:   return 7'd7;
      default: return 7'd15;
    endcase
  endfunction

endpackage

// File: rtl/ram_dev_addr.sv
// ram_dev_addr: burst word-address counter.
//   clk, rst      : clock / synchronous active-high reset
//   load, ld_addr : load start address (CA2)
//   step          : advance to the next word
//   wrap          : burst is wrapped (CA[45] = 0); only honoured with RAM_DEV_WRAP_EN
//   wrap_sel      : CR0[1:0] group-size code
//   addr          : current word address
// Linear bursts roll over naturally at 2^AW. With RAM_DEV_WRAP_EN defined,
// wrapped bursts keep the upper bits and wrap the low bits inside the group.
module ram_dev_addr
  import ram_dev_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] ld_addr,
  input  logic          step,
  input  logic          wrap,
  input  logic [1:0]    wrap_sel,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] nxt;

`ifdef RAM_DEV_WRAP_EN
  logic [AW-1:0] msk;
  assign msk = AW'(wrap_mask(wrap_sel));
  always_comb begin
    nxt = addr + AW'(1);
    if (wrap) nxt = (addr & ~msk) | ((addr + AW'(1)) & msk);
  end
`else
  logic unused_ok;
  assign unused_ok = ^{wrap, wrap_sel};
  assign nxt = addr + AW'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst)       addr <= '0;
    else if (load) addr <= ld_addr;
    else if (step) addr <= nxt;
  end

endmodule

// File: rtl/ram_dev.sv
// ram_dev: HyperBus responder (device side) at the de-serialised word level.
// One 16-bit word per clk: [15:8] rising-edge byte, [7:0] falling-edge byte.
// Ports:
//   clk, rst                 : clock / synchronous active-high reset
//   dev_cs_n                 : chip select, active low
//   dev_adq_in, dev_rwds_in  : CA/write word, write byte mask {hi,lo} (1 = masked)
//   dev_adq_out, dev_adq_oe  : read word and its output enable
//   dev_rwds_out, dev_rwds_oe: RWDS levels {rise,fall} and enable
//   dev_collide              : refresh collision (sampled in CA0), forces 2x latency
//   mem_*                    : synchronous memory port, mem_rdat valid 1 cycle after mem_ren
//   cr0_q, cr1_q             : configuration registers
// Optional: define RAM_DEV_WRAP_EN to honour wrapped bursts (CA[45] = 0).
module ram_dev
  import ram_dev_pkg::*;
#(
  parameter int          AW      = 22,
  parameter logic [15:0] CR0_RST = 16'h8F1F,
  parameter logic [15:0] CR1_RST = 16'h0002
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dev_cs_n,
  input  logic [15:0]   dev_adq_in,
  input  logic [1:0]    dev_rwds_in,
  output logic [15:0]   dev_adq_out,
  output logic          dev_adq_oe,
  output logic [1:0]    dev_rwds_out,
  output logic          dev_rwds_oe,
  input  logic          dev_collide,
  output logic          mem_ren,
  output logic [1:0]    mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdat,
  input  logic [15:0]   mem_rdat,
  output logic [15:0]   cr0_q,
  output logic [15:0]   cr1_q
);

  state_t      state, state_nxt;
  logic [15:0] ca_hi, ca_mid;
  logic        ca_crsel;   // CA[0]: register select
  logic        lat2x;
  logic [4:0]  lat_cnt;
  logic        reg_done;
  logic [15:0] cr0, cr1;

  logic        lat2x_now;
  logic        is_rd, is_reg;
  logic        addr_load, addr_step;
  logic [31:0] wa_full;
  logic [AW-1:0] addr;
  logic        unused_ok;

  // CA0 uses the live collide input; later CA words use the latched value.
  assign lat2x_now = cr0[3] | dev_collide;
  assign is_rd     = ca_hi[CA_RW-32];
  assign is_reg    = ca_hi[CA_AS-32];

  // Word address {CA[44:16], CA[2:0]}; only valid while in CA2.
  assign wa_full   = {ca_hi[12:0], ca_mid, dev_adq_in[2:0]};
  assign unused_ok = ^wa_full;

  ram_dev_addr #(.AW(AW)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (addr_load),
    .ld_addr  (wa_full[AW-1:0]),
    .step     (addr_step),
    .wrap     (~ca_hi[CA_BT-32]),
    .wrap_sel (cr0[1:0]),
    .addr     (addr)
  );

  assign mem_addr = addr;
  assign cr0_q    = cr0;
  assign cr1_q    = cr1;

  always_comb begin
    state_nxt    = state;
    dev_adq_out  = '0;
    dev_adq_oe   = 1'b0;
    dev_rwds_out = '0;
    dev_rwds_oe  = 1'b0;
    mem_ren      = 1'b0;
    mem_wen      = '0;
    mem_wdat     = '0;
    addr_load    = 1'b0;
    addr_step    = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_CA1 == S_CA1 && !dev_cs_n ? S_CA0 : S_IDLE;
      S_CA0: begin
        dev_rwds_oe  = 1'b1;
        dev_rwds_out = {2{lat2x_now}};
        state_nxt    = S_CA1;
      end
      S_CA1: begin
        dev_rwds_oe  = 1'b1;
        dev_rwds_out = {2{lat2x}};
        state_nxt    = S_CA2;
      end
      S_CA2: begin
        dev_rwds_oe  = 1'b1;
        dev_rwds_out = {2{lat2x}};
        addr_load    = 1'b1;
        state_nxt    = (!is_rd && is_reg) ? S_REGW : S_LAT;
      end
      S_LAT: begin
        if (lat_cnt == '0) begin
          // Prefetch the first word so it is on mem_rdat in the first RD cycle.
          if (is_rd && !is_reg) begin
            mem_ren   = 1'b1;
            addr_step = 1'b1;
          end
          state_nxt = is_rd ? S_RD : S_WR;
        end
      end
      S_RD: begin
        dev_adq_oe   = 1'b1;
        dev_rwds_oe  = 1'b1;
        dev_rwds_out = 2'b10;
        if (is_reg) begin
          dev_adq_out = ca_crsel ? cr1 : cr0;
        end else begin
          dev_adq_out = mem_rdat;
          mem_ren     = 1'b1;
          addr_step   = 1'b1;
        end
      end
      S_WR: begin
        mem_wen   = ~dev_rwds_in;
        mem_wdat  = dev_adq_in;
        addr_step = 1'b1;
      end
      S_REGW: ;
      default: state_nxt = S_IDLE;
    endcase
    // Deselect always wins; the current cycle's word is still served above.
    if (dev_cs_n) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ca_hi    <= '0;
      ca_mid   <= '0;
      ca_crsel <= 1'b0;
      lat2x    <= 1'b0;
      lat_cnt  <= '0;
      reg_done <= 1'b0;
      cr0      <= CR0_RST;
      cr1      <= CR1_RST;
    end else begin
      state <= state_nxt;
      case (state)
        S_CA0: begin
          ca_hi <= dev_adq_in;
          lat2x <= lat2x_now;
        end
        S_CA1: ca_mid <= dev_adq_in;
        S_CA2: begin
          ca_crsel <= dev_adq_in[0];
          lat_cnt  <= lat_clocks(cr0[7:4], lat2x) - 5'd1;
          reg_done <= 1'b0;
        end
        S_LAT: lat_cnt <= lat_cnt - 5'd1;
        S_REGW: begin
          // Only the first data word lands; the rest of the burst is dropped.
          if (!reg_done) begin
            reg_done <= 1'b1;
            if (ca_crsel) cr1 <= dev_adq_in;
            else          cr0 <= dev_adq_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
